// File: rtl/mux_4x1_reg_if.sv
// Bus bundle for mux_4x1_reg: capture enable, data/select inputs and registered results.
// With MUX_4X1_PARITY_EN defined the bundle also carries out_par.
interface mux_4x1_reg_if #(
    parameter int unsigned WIDTH = 1
);
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             s1;
    logic             s0;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic [1:0]       sel_q;
`ifdef MUX_4X1_PARITY_EN
    logic             out_par;

    modport master (
        output en, a, b, c, d, s1, s0,
        input  out, out_valid, sel_q, out_par
    );

    modport slave (
        input  en, a, b, c, d, s1, s0,
        output out, out_valid, sel_q, out_par
    );
`else
    modport master (
        output en, a, b, c, d, s1, s0,
        input  out, out_valid, sel_q
    );

    modport slave (
        input  en, a, b, c, d, s1, s0,
        output out, out_valid, sel_q
    );
`endif
endinterface

// File: rtl/mux_4x1_reg.sv
// Registered 4-to-1 multiplexer with one-cycle latency and a valid strobe.
// Optional registered parity output enabled by defining MUX_4X1_PARITY_EN.
module mux_4x1_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_4x1_reg_if.slave  bus
);

    logic [1:0]       sel;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;
    logic [1:0]       sel_q_q;

    assign sel = {bus.s1, bus.s0};

    always_comb begin
        sel_data = '0;
        unique case (sel)
            2'b00:   sel_data = bus.a;
            2'b01:   sel_data = bus.b;
            2'b10:   sel_data = bus.c;
            default: sel_data = bus.d;
        endcase
    end

    // out_valid tracks en every cycle; data and select only move on a capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sel_q_q     <= 2'b00;
        end else begin
            out_valid_q <= bus.en;
            if (bus.en) begin
                out_q   <= sel_data;
                sel_q_q <= sel;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sel_q     = sel_q_q;

`ifdef MUX_4X1_PARITY_EN
    logic out_par_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_par_q <= 1'b0;
        end else if (bus.en) begin
            out_par_q <= ^sel_data;
        end
    end

    assign bus.out_par = out_par_q;
`endif

endmodule

// File: tb/tb_mux_4x1_reg.sv
// Self-checking bench for mux_4x1_reg: directed vector table, hand sequences and
// a randomized run against a behavioural model (parity checked when MUX_4X1_PARITY_EN is set).
module tb_mux_4x1_reg;

    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    mux_4x1_reg_if #(.WIDTH(WIDTH)) bus ();

    mux_4x1_reg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst_n;
        logic             en;
        logic [1:0]       sel;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] exp_out;
        logic             exp_valid;
        logic [1:0]       exp_sel;
        logic             exp_par;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] s,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d,
                                input logic [WIDTH-1:0] eo, input logic ev,
                                input logic [1:0] es, input logic ep);
        vec_t v;
        v.rst_n = r; v.en = e; v.sel = s;
        v.a = a; v.b = b; v.c = c; v.d = d;
        v.exp_out = eo; v.exp_valid = ev; v.exp_sel = es; v.exp_par = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] s,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        rst_n  = r;
        bus.en = e;
        bus.s1 = s[1];
        bus.s0 = s[0];
        bus.a  = a;
        bus.b  = b;
        bus.c  = c;
        bus.d  = d;
    endtask

    task automatic check_outputs(input string tag, input logic [WIDTH-1:0] eo,
                                 input logic ev, input logic [1:0] es, input logic ep);
        check({tag, ".out"}, 32'(bus.out), 32'(eo));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
        check({tag, ".sel_q"}, 32'(bus.sel_q), 32'(es));
`ifdef MUX_4X1_PARITY_EN
        check({tag, ".out_par"}, 32'(bus.out_par), 32'(ep));
`else
        if (ep === 1'bx) check({tag, ".par_unused"}, 32'd0, 32'd1);
`endif
    endtask

    // Reference model state: what the outputs should be after the most recent edge
    logic [WIDTH-1:0] m_out;
    logic             m_valid;
    logic [1:0]       m_sel;
    logic             m_par;

    task automatic model_step(input logic r, input logic e, input logic [1:0] s,
                              input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] inputs [4];
        inputs[0] = a; inputs[1] = b; inputs[2] = c; inputs[3] = d;
        if (!r) begin
            m_out = '0; m_valid = 1'b0; m_sel = 2'b00; m_par = 1'b0;
        end else if (e) begin
            m_out   = inputs[s];
            m_sel   = s;
            m_valid = 1'b1;
            m_par   = ^inputs[s];
        end else begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        logic [WIDTH-1:0] sweep_exp [4];
        logic             sweep_par [4];
        passed = 0;
        total  = 0;
        drive(1'b0, 1'b0, 2'b00, '0, '0, '0, '0);

        // Test plan steps 1-5 ("1" is 8'h01), then decode with distinct data, then reset while en=1
        vecs.push_back(mk(0, 1, 2'b00, 1, 1, 1, 1, 0, 0, 2'b00, 0));
        vecs.push_back(mk(0, 1, 2'b00, 1, 1, 1, 1, 0, 0, 2'b00, 0));
        vecs.push_back(mk(1, 1, 2'b00, 1, 1, 1, 1, 1, 1, 2'b00, 1));
        vecs.push_back(mk(1, 1, 2'b01, 1, 0, 1, 1, 0, 1, 2'b01, 0));
        vecs.push_back(mk(1, 1, 2'b10, 1, 1, 1, 1, 1, 1, 2'b10, 1));
        vecs.push_back(mk(1, 1, 2'b11, 1, 1, 1, 0, 0, 1, 2'b11, 0));
        vecs.push_back(mk(1, 0, 2'b00, 1, 1, 1, 1, 0, 0, 2'b11, 0));
        vecs.push_back(mk(1, 0, 2'b00, 1, 1, 1, 1, 0, 0, 2'b11, 0));
        vecs.push_back(mk(1, 0, 2'b00, 1, 1, 1, 1, 0, 0, 2'b11, 0));
        vecs.push_back(mk(1, 1, 2'b00, 8'h11, 8'h22, 8'h34, 8'h48, 8'h11, 1, 2'b00, 0));
        vecs.push_back(mk(1, 1, 2'b11, 8'h11, 8'h22, 8'h34, 8'h48, 8'h48, 1, 2'b11, 0));
        vecs.push_back(mk(1, 1, 2'b10, 8'h11, 8'h22, 8'h34, 8'h49, 8'h34, 1, 2'b10, 1));
        vecs.push_back(mk(1, 1, 2'b01, 8'h11, 8'h23, 8'h34, 8'h48, 8'h23, 1, 2'b01, 1));
        vecs.push_back(mk(1, 0, 2'b10, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h23, 0, 2'b01, 1));
        vecs.push_back(mk(0, 1, 2'b11, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 0, 2'b00, 0));
        vecs.push_back(mk(1, 0, 2'b11, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 0, 2'b00, 0));
        vecs.push_back(mk(1, 1, 2'b11, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hDD, 1, 2'b11, 0));
        vecs.push_back(mk(1, 1, 2'b00, 8'h80, 8'hBB, 8'hCC, 8'hDD, 8'h80, 1, 2'b00, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].sel,
                  vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_valid,
                          vecs[i].exp_sel, vecs[i].exp_par);
        end

        // Back-to-back select sweep (test plan step 6)
        sweep_exp[0] = 8'h01; sweep_exp[1] = 8'h03; sweep_exp[2] = 8'h07; sweep_exp[3] = 8'hFF;
        sweep_par[0] = 1'b1;  sweep_par[1] = 1'b0;  sweep_par[2] = 1'b1;  sweep_par[3] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 1'b1, 2'(s), 8'h01, 8'h03, 8'h07, 8'hFF);
            @(posedge clk);
            #1;
            check_outputs($sformatf("sweep%0d", s), sweep_exp[s], 1'b1, 2'(s), sweep_par[s]);
        end

        // Inputs changing between edges must not reach out before the next edge
        drive(1'b1, 1'b0, 2'b00, 8'h5A, 8'h00, 8'h00, 8'h00);
        #2;
        check("comb_path.out", 32'(bus.out), 32'hFF);
        @(posedge clk);
        #1;
        check("hold_after_sweep.out", 32'(bus.out), 32'hFF);

        // Randomized run against the model, including sporadic resets
        m_out = bus.out; m_valid = 1'b0; m_sel = 2'b11; m_par = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic             r;
            logic             e;
            logic [1:0]       s;
            logic [WIDTH-1:0] ra, rb, rc, rd;
            r  = ($urandom_range(0, 19) != 0);
            e  = ($urandom_range(0, 3) != 0);
            s  = 2'($urandom_range(0, 3));
            ra = WIDTH'($urandom); rb = WIDTH'($urandom);
            rc = WIDTH'($urandom); rd = WIDTH'($urandom);
            drive(r, e, s, ra, rb, rc, rd);
            model_step(r, e, s, ra, rb, rc, rd);
            @(posedge clk);
            #1;
            check_outputs($sformatf("rand%0d", i), m_out, m_valid, m_sel, m_par);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
